// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types for the multi-cycle control FSM: state encoding, opcode classes,
// ALU operation codes and the registered control bundle.
package multicycle_ctrl_fsm_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CLS_W   = 3;
    localparam int unsigned ALUOP_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    typedef enum logic [CLS_W-1:0] {
        CLS_NOP = 3'd0,
        CLS_R   = 3'd1,
        CLS_I   = 3'd2,
        CLS_LD  = 3'd3,
        CLS_ST  = 3'd4,
        CLS_BR  = 3'd5,
        CLS_J   = 3'd6,
        CLS_ILL = 3'd7
    } cls_t;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_CMP = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_I   = 2'b11;

    typedef struct packed {
        logic               ir_load;
        logic               pc_write;
        logic               regdest;
        logic               regwrite;
        logic               alusrc;
        logic               memread;
        logic               memwrite;
        logic               mem_to_reg;
        logic               branch;
        logic               jump;
        logic [ALUOP_W-1:0] aluop;
        logic               busy;
    } ctrl_t;

    function automatic logic [ALUOP_W-1:0] aluop_of(input cls_t c);
        case (c)
            CLS_R:   aluop_of = ALUOP_R;
            CLS_I:   aluop_of = ALUOP_I;
            CLS_BR:  aluop_of = ALUOP_CMP;
            default: aluop_of = ALUOP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_classifier.sv
// Combinational opcode classifier: maps an opcode to its instruction class and
// flags opcodes outside the mapped set (including any nonzero upper bits).
module opcode_classifier
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output cls_t                cls,
    output logic                legal
);

    logic [5:0] low;
    logic       upper_zero;

    assign low        = opcode[5:0];
    assign upper_zero = ((opcode >> 6) == '0);

    always_comb begin
        cls = CLS_ILL;
        case (low)
            6'd0:                                        cls = CLS_NOP;
            6'd1, 6'd2, 6'd3, 6'd4, 6'd7, 6'd8, 6'd24:   cls = CLS_R;
            6'd5, 6'd6, 6'd9, 6'd10, 6'd11, 6'd12, 6'd25: cls = CLS_I;
            6'd13:                                       cls = CLS_LD;
            6'd14:                                       cls = CLS_ST;
            6'd15, 6'd16, 6'd17, 6'd18, 6'd19, 6'd20:    cls = CLS_BR;
            6'd21, 6'd22, 6'd23:                         cls = CLS_J;
            default:                                     cls = CLS_ILL;
        endcase
        if (!upper_zero) begin
            cls = CLS_ILL;
        end
    end

    assign legal = (cls != CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle instruction control: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives registered datapath controls, with a bounded wait on data memory.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 6,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                ir_load,
    output logic                pc_write,
    output logic                regdest,
    output logic                regwrite,
    output logic                alusrc,
    output logic                memread,
    output logic                memwrite,
    output logic                mem_to_reg,
    output logic                branch,
    output logic                jump,
    output logic [1:0]          aluop,
    output logic                busy,
    output logic                illegal_op,
    output logic                timeout,
    output logic [2:0]          state
);

    state_t              state_q, state_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;
    cls_t                cls;
    logic                legal;

    opcode_classifier #(.OPCODE_W(OPCODE_W)) u_classifier (
        .opcode (opcode_q),
        .cls    (cls),
        .legal  (legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            ctrl_q    <= '0;
            opcode_q  <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            opcode_q  <= opcode_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Transition pulses come from the decision taken in the current state;
    // level controls are decoded from the state being entered.
    always_comb begin
        state_d   = state_q;
        ctrl_d    = '0;
        opcode_d  = opcode_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    opcode_d       = opcode;
                    ctrl_d.ir_load = 1'b1;
                    state_d        = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!legal) begin
                    illegal_d       = 1'b1;
                    ctrl_d.pc_write = 1'b1;
                    state_d         = ST_FETCH;
                end else if (cls == CLS_NOP) begin
                    ctrl_d.pc_write = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls)
                    CLS_BR: begin
                        ctrl_d.branch   = 1'b1;
                        ctrl_d.pc_write = 1'b1;
                        state_d         = ST_FETCH;
                    end
                    CLS_J: begin
                        ctrl_d.jump     = 1'b1;
                        ctrl_d.pc_write = 1'b1;
                        state_d         = ST_FETCH;
                    end
                    CLS_LD, CLS_ST: begin
                        cnt_d   = '0;
                        state_d = ST_MEM;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                // A ready arriving on the last allowed cycle still completes the access.
                if (mem_ready) begin
                    cnt_d = '0;
                    if (cls == CLS_LD) begin
                        state_d = ST_WB;
                    end else begin
                        ctrl_d.pc_write = 1'b1;
                        state_d         = ST_FETCH;
                    end
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    cnt_d           = '0;
                    timeout_d       = 1'b1;
                    ctrl_d.pc_write = 1'b1;
                    state_d         = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                ctrl_d.pc_write = 1'b1;
                state_d         = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase

        ctrl_d.busy = (state_d != ST_FETCH);
        case (state_d)
            ST_EXEC: begin
                ctrl_d.regdest = (cls == CLS_R);
                ctrl_d.alusrc  = (cls == CLS_I) || (cls == CLS_LD) || (cls == CLS_ST);
                ctrl_d.aluop   = aluop_of(cls);
            end
            ST_MEM: begin
                ctrl_d.memread  = (cls == CLS_LD);
                ctrl_d.memwrite = (cls == CLS_ST);
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.aluop    = ALUOP_ADD;
            end
            ST_WB: begin
                ctrl_d.regwrite   = 1'b1;
                ctrl_d.regdest    = (cls == CLS_R);
                ctrl_d.mem_to_reg = (cls == CLS_LD);
            end
            default: ;
        endcase
    end

    assign ir_load    = ctrl_q.ir_load;
    assign pc_write   = ctrl_q.pc_write;
    assign regdest    = ctrl_q.regdest;
    assign regwrite   = ctrl_q.regwrite;
    assign alusrc     = ctrl_q.alusrc;
    assign memread    = ctrl_q.memread;
    assign memwrite   = ctrl_q.memwrite;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign aluop      = ctrl_q.aluop;
    assign busy       = ctrl_q.busy;
    assign illegal_op = illegal_q;
    assign timeout    = timeout_q;
    assign state      = 3'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: builds each instruction's expected per-cycle
// control trace from its class and memory wait, then compares every cycle.
module tb_multicycle_ctrl_fsm;

    localparam int unsigned TMO = 15;

    localparam logic [2:0] S_FET = 3'd0;
    localparam logic [2:0] S_DEC = 3'd1;
    localparam logic [2:0] S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam int C_NOP = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4, C_BR = 5, C_J = 6, C_ILL = 7;

    typedef struct packed {
        logic       ir_load;
        logic       pc_write;
        logic       regdest;
        logic       regwrite;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
        logic       busy;
        logic       illegal;
        logic       tmo;
        logic [2:0] st;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst, instr_valid, mem_ready;
    logic [5:0] opcode;
    logic       ir_load, pc_write, regdest, regwrite, alusrc, memread, memwrite;
    logic       mem_to_reg, branch, jump, busy, illegal_op, timeout;
    logic [1:0] aluop;
    logic [2:0] state;

    obs_t obs, exp_now;
    logic sticky_ill, sticky_to;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
        .mem_ready(mem_ready), .ir_load(ir_load), .pc_write(pc_write),
        .regdest(regdest), .regwrite(regwrite), .alusrc(alusrc),
        .memread(memread), .memwrite(memwrite), .mem_to_reg(mem_to_reg),
        .branch(branch), .jump(jump), .aluop(aluop), .busy(busy),
        .illegal_op(illegal_op), .timeout(timeout), .state(state)
    );

    assign obs = {ir_load, pc_write, regdest, regwrite, alusrc, memread, memwrite,
                  mem_to_reg, branch, jump, aluop, busy, illegal_op, timeout, state};

    function automatic int cls_of(input logic [5:0] op);
        if (op == 6'd0)                                   return C_NOP;
        if (op inside {[6'd1:6'd4], 6'd7, 6'd8, 6'd24})   return C_R;
        if (op inside {6'd5, 6'd6, [6'd9:6'd12], 6'd25})  return C_I;
        if (op == 6'd13)                                  return C_LD;
        if (op == 6'd14)                                  return C_ST;
        if (op inside {[6'd15:6'd20]})                    return C_BR;
        if (op inside {[6'd21:6'd23]})                    return C_J;
        return C_ILL;
    endfunction

    function automatic obs_t base(input logic [2:0] s);
        obs_t e;
        e         = '0;
        e.st      = s;
        e.busy    = (s != S_FET);
        e.illegal = sticky_ill;
        e.tmo     = sticky_to;
        return e;
    endfunction

    task automatic check(input string tag, input obs_t e);
        n_vec++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic tick(input logic r, input logic iv, input logic [5:0] op, input logic rdy);
        rst         = r;
        instr_valid = iv;
        opcode      = op;
        mem_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check("idle", exp_now);
            tick(1'b0, 1'b0, 6'($urandom), 1'($urandom));
            exp_now = base(S_FET);
        end
    endtask

    // w = wait cycles before ready; rdy_ok=0 means ready never comes.
    // rst_at >= 0 asserts reset in that trace cycle (0 = DECODE).
    task automatic run_instr(input logic [5:0] op, input int w, input bit rdy_ok, input int rst_at);
        obs_t eq[$];
        logic rq[$];
        obs_t e, fin;
        int   c, n;
        c = cls_of(op);
        check($sformatf("issue op%0d", op), exp_now);
        tick(1'b0, 1'b1, op, 1'($urandom));

        e = base(S_DEC);
        e.ir_load = 1'b1;
        eq.push_back(e); rq.push_back(1'($urandom));
        if (c != C_NOP && c != C_ILL) begin
            e = base(S_EXE);
            e.regdest = (c == C_R);
            e.alusrc  = (c == C_I) || (c == C_LD) || (c == C_ST);
            e.aluop   = (c == C_R) ? 2'b10 : (c == C_I) ? 2'b11 : (c == C_BR) ? 2'b01 : 2'b00;
            eq.push_back(e); rq.push_back(1'($urandom));
        end
        if (c == C_LD || c == C_ST) begin
            n = rdy_ok ? w + 1 : int'(TMO);
            for (int i = 0; i < n; i++) begin
                e = base(S_MEM);
                e.memread  = (c == C_LD);
                e.memwrite = (c == C_ST);
                e.alusrc   = 1'b1;
                eq.push_back(e);
                rq.push_back(rdy_ok && (i == n - 1));
            end
        end
        if (c == C_R || c == C_I || (c == C_LD && rdy_ok)) begin
            e = base(S_WB);
            e.regwrite   = 1'b1;
            e.regdest    = (c == C_R);
            e.mem_to_reg = (c == C_LD);
            eq.push_back(e); rq.push_back(1'($urandom));
        end
        if (c == C_ILL) sticky_ill = 1'b1;
        if ((c == C_LD || c == C_ST) && !rdy_ok) sticky_to = 1'b1;
        fin = base(S_FET);
        fin.pc_write = 1'b1;
        fin.branch   = (c == C_BR);
        fin.jump     = (c == C_J);

        foreach (eq[i]) begin
            check($sformatf("op%0d cyc%0d", op, i + 1), eq[i]);
            if (i == rst_at) begin
                tick(1'b1, 1'b0, 6'($urandom), 1'($urandom));
                sticky_ill = 1'b0;
                sticky_to  = 1'b0;
                exp_now    = base(S_FET);
                rst        = 1'b0;
                return;
            end
            tick(1'b0, 1'($urandom), 6'($urandom), rq[i]);
        end
        exp_now = fin;
    endtask

    initial begin
        logic [5:0] rop;
        sticky_ill  = 1'b0;
        sticky_to   = 1'b0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        opcode      = 6'd0;
        mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_now = base(S_FET);
        idle(2);

        run_instr(6'd1, 0, 1'b1, -1);      // R-type
        run_instr(6'd13, 2, 1'b1, -1);     // LD, two waits
        run_instr(6'd14, 14, 1'b1, -1);    // ST, ready on the limit cycle
        run_instr(6'd13, 14, 1'b1, -1);    // LD, ready on the limit cycle
        run_instr(6'd0, 0, 1'b1, -1);      // NOP
        run_instr(6'd14, 0, 1'b0, -1);     // ST, never ready
        idle(1);
        run_instr(6'd40, 0, 1'b1, -1);     // illegal
        run_instr(6'd21, 0, 1'b1, -1);     // J after illegal
        run_instr(6'd17, 0, 1'b1, -1);     // BR
        run_instr(6'd22, 0, 1'b1, -1);     // J back-to-back
        run_instr(6'd5, 0, 1'b1, -1);      // I-type
        run_instr(6'd13, 5, 1'b1, 3);      // LD, reset during MEM
        idle(2);

        for (int k = 0; k < 60; k++) begin
            rop = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 25)) : 6'($urandom);
            run_instr(rop, int'($urandom_range(0, 4)), ($urandom_range(0, 5) != 0),
                      (k == 30) ? 1 : -1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
